// File: rtl/pulse_gen_pkg.sv
// Shared encodings for the multi-channel edge-to-pulse generator.
//   mode_e  : per-channel edge select (rising, falling, both, disabled)
//   state_e : per-channel pulse FSM state
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_chan.sv
// One channel of the pulse generator: input synchronizer, edge detector,
// IDLE/PULSE FSM with length counter, and sticky overrun flag.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   in_i          : asynchronous level input
//   mode_i        : edge select (see pulse_gen_pkg::mode_e)
//   clr_ovr_i     : overrun clear strobe
//   pulse_o       : registered pulse, PULSE_LEN cycles per accepted edge
//   overrun_o     : registered sticky overrun flag
module pulse_chan #(
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    input  logic       clr_ovr_i,
    output logic       pulse_o,
    output logic       overrun_o
);
    import pulse_gen_pkg::*;

    localparam int unsigned    CNT_W    = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

    logic             s;
    logic             p_q;
    logic             edge_hit;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             pulse_q, pulse_d;

    // Input synchronizer; zero stages feeds the input straight through.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= in_i;
                    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Edge qualification uses the mode present in the current cycle.
    always_comb begin
        edge_hit = 1'b0;
        case (mode_i)
            MODE_RISE: edge_hit = s & ~p_q;
            MODE_FALL: edge_hit = ~s & p_q;
            MODE_BOTH: edge_hit = s ^ p_q;
            default:   edge_hit = 1'b0;
        endcase
    end

    // State, counter and flag registers; p tracks s even while pulsing.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            p_q     <= s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state: edges in PULSE (including the last cycle) only flag overrun.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_hit) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Set beats a simultaneous clear.
        if (edge_hit && (state_q == ST_PULSE)) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        pulse_d = (state_d == ST_PULSE);
    end

    assign pulse_o   = pulse_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel edge-to-pulse generator: CHANNELS independent pulse_chan
// instances plus a combinational OR of their pulses.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   in        : per-channel level inputs
//   mode      : per-channel edge select, channel i at [2i+1:2i]
//   clr_ovr   : per-channel overrun clear strobes
//   pulse     : per-channel registered pulses
//   overrun   : per-channel registered sticky overrun flags
//   any_pulse : OR of all pulse bits (combinational)
module pulse_gen_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr_ovr,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   overrun,
    output logic                  any_pulse
);
    import pulse_gen_pkg::*;

    generate
        for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
            pulse_chan #(
                .PULSE_LEN   (PULSE_LEN),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .in_i      (in[i]),
                .mode_i    (mode[2*i +: 2]),
                .clr_ovr_i (clr_ovr[i]),
                .pulse_o   (pulse[i]),
                .overrun_o (overrun[i])
            );
        end
    endgenerate

    assign any_pulse = |pulse;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: two instances (PULSE_LEN 1 and 4) share stimulus.
// A cycle model pushes expected outputs per clock; they are popped and
// compared after each rising edge. Directed pulse-count checks back it up.
module tb_pulse_gen_multi;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clr_ovr;
    logic [3:0] pulse1, ovr1, pulse4, ovr4;
    logic       any1, any4;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] p1;
        logic [3:0] o1;
        logic [3:0] p4;
        logic [3:0] o4;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: [instance][channel]
    bit ms0 [2][4];
    bit ms1 [2][4];
    bit mp  [2][4];
    bit movr[2][4];
    int mrem[2][4];

    int cnt1[4];
    int cnt4[4];
    int cnt_any4;

    pulse_gen_multi #(.CHANNELS(4), .PULSE_LEN(1), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .in(din), .mode(mode), .clr_ovr(clr_ovr),
        .pulse(pulse1), .overrun(ovr1), .any_pulse(any1)
    );

    pulse_gen_multi #(.CHANNELS(4), .PULSE_LEN(4), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .rst(rst), .in(din), .mode(mode), .clr_ovr(clr_ovr),
        .pulse(pulse4), .overrun(ovr4), .any_pulse(any4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                bit s;
                bit hit;
                bit busy;
                int len;
                len = (m == 0) ? 1 : 4;
                if (rst) begin
                    ms0[m][c]  = 1'b0;
                    ms1[m][c]  = 1'b0;
                    mp[m][c]   = 1'b0;
                    movr[m][c] = 1'b0;
                    mrem[m][c] = 0;
                end else begin
                    s = ms1[m][c];
                    case (mode[2*c +: 2])
                        2'b00:   hit = s && !mp[m][c];
                        2'b01:   hit = !s && mp[m][c];
                        2'b10:   hit = s != mp[m][c];
                        default: hit = 1'b0;
                    endcase
                    busy = (mrem[m][c] > 0);
                    if (hit && busy) movr[m][c] = 1'b1;
                    else if (clr_ovr[c]) movr[m][c] = 1'b0;
                    if (busy) mrem[m][c] = mrem[m][c] - 1;
                    else if (hit) mrem[m][c] = len;
                    mp[m][c]  = s;
                    ms1[m][c] = ms0[m][c];
                    ms0[m][c] = din[c];
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            e.p1[c] = (mrem[0][c] > 0);
            e.o1[c] = movr[0][c];
            e.p4[c] = (mrem[1][c] > 0);
            e.o4[c] = movr[1][c];
        end
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_l1",   32'(pulse1), 32'(e.p1));
        chk("ovr_l1",     32'(ovr1),   32'(e.o1));
        chk("any_l1",     32'(any1),   32'(|e.p1));
        chk("pulse_l4",   32'(pulse4), 32'(e.p4));
        chk("ovr_l4",     32'(ovr4),   32'(e.o4));
        chk("any_l4",     32'(any4),   32'(|e.p4));
        for (int c = 0; c < 4; c++) begin
            if (pulse1[c] === 1'b1) cnt1[c]++;
            if (pulse4[c] === 1'b1) cnt4[c]++;
        end
        if (any4 === 1'b1) cnt_any4++;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            compare_out();
        end
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < 4; c++) begin
            cnt1[c] = 0;
            cnt4[c] = 0;
        end
        cnt_any4 = 0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        din     = 4'h0;
        mode    = 8'h00;
        clr_ovr = 4'h0;
        clr_cnt();

        // Reset state
        tick(3);
        chk("rst_pulse", 32'(pulse4), 32'd0);
        chk("rst_ovr",   32'(ovr4),   32'd0);
        chk("rst_any",   32'(any4),   32'd0);
        rst = 1'b0;
        tick(3);

        // Single rising edge, latency of three edges, held level
        clr_cnt();
        din[0] = 1'b1;
        tick(2);
        chk("a_lat_early", 32'(pulse1[0]), 32'd0);
        tick(1);
        chk("a_lat_l1", 32'(pulse1[0]), 32'd1);
        chk("a_lat_l4", 32'(pulse4[0]), 32'd1);
        tick(1);
        chk("a_len_l1", 32'(pulse1[0]), 32'd0);
        tick(8);
        chk("a_cnt_l1", 32'(cnt1[0]), 32'd1);
        chk("a_cnt_l4", 32'(cnt4[0]), 32'd4);
        din[0] = 1'b0;
        tick(4);

        // Both-edge mode on channel 1
        mode = 8'b00_00_10_00;
        clr_cnt();
        din[1] = 1'b1;
        tick(10);
        din[1] = 1'b0;
        tick(10);
        chk("b_cnt_l4", 32'(cnt4[1]), 32'd8);
        chk("b_cnt_l1", 32'(cnt1[1]), 32'd2);
        chk("b_ovr_l4", 32'(ovr4[1]), 32'd0);

        // Rising edges two cycles apart on channel 2
        clr_cnt();
        din[2] = 1'b1; tick(1);
        din[2] = 1'b0; tick(1);
        din[2] = 1'b1; tick(8);
        chk("c_cnt_l4", 32'(cnt4[2]), 32'd4);
        chk("c_ovr_l4", 32'(ovr4[2]), 32'd1);
        chk("c_cnt_l1", 32'(cnt1[2]), 32'd2);
        chk("c_ovr_l1", 32'(ovr1[2]), 32'd0);
        clr_ovr[2] = 1'b1; tick(1);
        clr_ovr[2] = 1'b0;
        chk("c_clr", 32'(ovr4[2]), 32'd0);
        din[2] = 1'b0; tick(4);
        // Clear strobe coincident with a new overrun
        din[2] = 1'b1; tick(1);
        din[2] = 1'b0; tick(1);
        din[2] = 1'b1; tick(2);
        clr_ovr[2] = 1'b1; tick(1);
        chk("c_set_wins", 32'(ovr4[2]), 32'd1);
        clr_ovr[2] = 1'b0; tick(3);
        chk("c_sticky", 32'(ovr4[2]), 32'd1);
        din[2] = 1'b0; tick(4);

        // Disabled channel 3 ignores toggles
        mode[7:6] = 2'b11;
        clr_cnt();
        for (int t = 0; t < 5; t++) begin
            din[3] = ~din[3];
            tick(2);
        end
        tick(3);
        chk("d_off_l1", 32'(cnt1[3]), 32'd0);
        chk("d_off_l4", 32'(cnt4[3]), 32'd0);
        // Falling-triggered pulse, mode switched to 01 mid-pulse
        mode[7:6] = 2'b10; tick(4);
        clr_cnt();
        din[3] = 1'b0; tick(3);
        mode[7:6] = 2'b01; tick(6);
        chk("d_sw01_l4", 32'(cnt4[3]), 32'd4);
        chk("d_sw01_l1", 32'(cnt1[3]), 32'd1);
        din[3] = 1'b1; tick(4);
        // Falling-triggered pulse, mode switched to 11 mid-pulse
        clr_cnt();
        din[3] = 1'b0; tick(3);
        mode[7:6] = 2'b11; tick(6);
        chk("d_sw11_l4", 32'(cnt4[3]), 32'd4);
        chk("d_sw11_l1", 32'(cnt1[3]), 32'd1);

        // Reset in the second cycle of a pulse, input held across release
        mode = 8'h00;
        din  = 4'h0;
        tick(4);
        din[0] = 1'b1;
        tick(4);
        chk("e_mid_pulse", 32'(pulse4[0]), 32'd1);
        rst = 1'b1; tick(1);
        chk("e_rst_pulse", 32'(pulse4), 32'd0);
        chk("e_rst_ovr",   32'(ovr4),   32'd0);
        tick(1);
        rst = 1'b0;
        clr_cnt();
        tick(10);
        chk("e_rel_l4", 32'(cnt4[0]), 32'd4);
        chk("e_rel_l1", 32'(cnt1[0]), 32'd1);

        // Simultaneous rising edges on all channels
        din = 4'h0; tick(6);
        clr_cnt();
        din = 4'hF; tick(3);
        chk("f_all_l4",  32'(pulse4), 32'hF);
        chk("f_all_l1",  32'(pulse1), 32'hF);
        chk("f_any_l4",  32'(any4),   32'd1);
        tick(7);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("f_cnt_l4_ch%0d", c), 32'(cnt4[c]), 32'd4);
        end
        chk("f_any_cnt", 32'(cnt_any4), 32'd4);

        // Random traffic against the model
        for (int t = 0; t < 300; t++) begin
            din     = 4'($urandom);
            mode    = 8'($urandom);
            clr_ovr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            rst     = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        rst     = 1'b0;
        clr_ovr = 4'h0;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_gen_multi.md
PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels (1..32).
REQ-002 Parameter PULSE_LEN, default 1: output pulse length in clk cycles (1..255).
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer flops per channel (0..3; 0 = inputs used directly).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in  input  CHANNELS  per-channel level inputs.
REQ-007 mode  input  2*CHANNELS  per-channel edge select, channel i uses bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-008 clr_ovr  input  CHANNELS  per-channel overrun clear strobe.
REQ-009 pulse  output  CHANNELS  per-channel registered pulse.
REQ-010 overrun  output  CHANNELS  per-channel sticky overrun flag, registered.
REQ-011 any_pulse  output  1  OR of all pulse bits.

Function
REQ-012 Each channel SHALL pass in[i] through SYNC_STAGES flops to give s[i], and register s[i] into p[i] every cycle, including during a pulse.
REQ-013 A qualifying edge SHALL be: rising = s & ~p; falling = ~s & p; both = s ^ p; disabled = never; evaluated with the mode value present in that cycle.
REQ-014 Per-channel FSM SHALL have two states, IDLE and PULSE; reset state IDLE.
REQ-015 IDLE -> PULSE on a qualifying edge; the length counter loads PULSE_LEN-1 on that edge.
REQ-016 In PULSE, the counter SHALL decrement each cycle; PULSE -> IDLE on the edge where the counter is 0.
REQ-017 pulse[i] SHALL be 1 exactly when channel i is in PULSE: high for exactly PULSE_LEN cycles per accepted edge.
REQ-018 Latency: pulse[i] SHALL rise SYNC_STAGES+1 clock edges after the edge at which in[i] first presents the qualifying level.
REQ-019 A qualifying edge while in PULSE SHALL NOT extend or restart the pulse and SHALL set overrun[i].
REQ-020 A qualifying edge in the final PULSE cycle (counter 0) SHALL also count as overrun; the FSM still returns to IDLE.
REQ-021 When set and clr_ovr[i] occur in the same cycle, the set SHALL win; otherwise clr_ovr[i] clears overrun[i] on the next edge.
REQ-022 Changing mode[i] to 11 or to another edge type during PULSE SHALL NOT truncate the active pulse.
REQ-023 The counter SHALL be $clog2(PULSE_LEN+1) bits wide and unsigned, and SHALL never wrap.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels each produce their own pulse.
REQ-025 any_pulse SHALL be combinational OR of the registered pulse bits, with no further register.

Reset
REQ-026 On rst=1 at a clock edge: all synchronizer flops, p, counters = 0; FSM = IDLE; pulse = 0; overrun = 0; any_pulse = 0.
REQ-027 Reset mid-pulse SHALL drop pulse in the next cycle, and no pulse resumes after reset release.
REQ-028 Because p resets to 0, an input held high through reset release in rising or both mode SHALL produce one pulse, after the latency in REQ-018.

Structure
REQ-029 Package pulse_gen_pkg SHALL hold the mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF) and the FSM state encodings (ST_IDLE, ST_PULSE).
REQ-030 Per-channel logic (synchronizer, edge detect, FSM, counter, overrun) SHALL be one sub-module pulse_chan, instantiated CHANNELS times by generate; the top holds only the OR reduction.

Verification
REQ-031 CHANNELS=4, SYNC_STAGES=2, PULSE_LEN=1, mode=00, in[0] 0->1 held -> pulse[0] high exactly 1 cycle, 3 edges after in rises; no further pulse while in held high.
REQ-032 PULSE_LEN=4, mode[1]=10, in[1] toggled 1, held 10 cycles, toggled 0 -> two pulses of 4 cycles each; overrun[1] stays 0.
REQ-033 PULSE_LEN=4, mode=00, rising edges on in[2] 2 cycles apart -> one 4-cycle pulse; overrun[2]=1 until a clr_ovr[2] strobe, then 0; a clr_ovr strobe coincident with a new overrun leaves overrun=1.
REQ-034 mode[3]=11, in[3] toggled 5 times -> pulse[3] stays 0; switch mode to 01 during a falling-triggered pulse on another run -> pulse length unaffected.
REQ-035 rst asserted in 2nd cycle of a 4-cycle pulse -> pulse=0 next cycle, overrun=0; in held high across release with mode=00 -> exactly one pulse after release.
REQ-036 Simultaneous rising edges on all 4 channels -> pulse=4'b1111 for PULSE_LEN cycles, any_pulse=1 over the same cycles.
